// File: rtl/ps2_hex_key_rx.sv
// PS/2 set-2 receiver that decodes hex-digit make codes into a first-word-fall-through nibble FIFO.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking of each received frame.
module ps2_hex_key_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clr,
    output logic [3:0]                    key_data,
    output logic                          key_valid,
    output logic [$clog2(FIFO_DEPTH):0]   key_count,
    output logic                          overflow,
    output logic                          frame_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t        state, state_nx;
    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fall, bit_in, timeout, frame_ok;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] idle_cnt;
    logic          break_flag, ext_flag;
    logic [3:0]    nib;
    logic          hit, push;

    // Sync chain resets to the idle-high line level so release never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign bit_in  = dat_sync[1];
    assign timeout = (idle_cnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = shreg[9] & (^shreg[8:0]);
`else
    assign frame_ok = shreg[9];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fall && !bit_in) state_nx = RECV;
            RECV:    if (timeout) state_nx = IDLE;
                     else if (fall && bit_cnt == 4'd10) state_nx = CHECK;
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        frame_err = ((state == CHECK) && !frame_ok) || ((state == RECV) && timeout);
        push      = (state == CHECK) && frame_ok && !break_flag && !ext_flag && hit;
    end

    // Shift is LSB-first: after ten edges shreg = {stop, parity, data[7:0]}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            idle_cnt   <= '0;
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (fall && !bit_in) bit_cnt <= 4'd1;
                end
                RECV: begin
                    if (fall) begin
                        shreg    <= {bit_in, shreg[9:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        if (shreg[7:0] == 8'hF0)      break_flag <= 1'b1;
                        else if (shreg[7:0] == 8'hE0) ext_flag   <= 1'b1;
                        else if (break_flag || ext_flag) begin
                            break_flag <= 1'b0;
                            ext_flag   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hit = 1'b1;
        nib = 4'h0;
        case (shreg[7:0])
            8'h45: nib = 4'h0;  8'h16: nib = 4'h1;  8'h1E: nib = 4'h2;  8'h26: nib = 4'h3;
            8'h25: nib = 4'h4;  8'h2E: nib = 4'h5;  8'h36: nib = 4'h6;  8'h3D: nib = 4'h7;
            8'h3E: nib = 4'h8;  8'h46: nib = 4'h9;  8'h1C: nib = 4'hA;  8'h32: nib = 4'hB;
            8'h21: nib = 4'hC;  8'h23: nib = 4'hD;  8'h24: nib = 4'hE;  8'h2B: nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop, full, do_push;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = rd_en && (count != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= nib;
    end

    // clr outranks any same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            if (push && full && !do_pop) overflow <= 1'b1;
        end
    end

    assign key_valid = (count != '0);
    assign key_count = count;
    assign key_data  = key_valid ? mem[rd_ptr] : 4'h0;
endmodule

// File: tb/tb_ps2_hex_key_rx.sv
// Self-checking bench: directed steps then random frames against a queue-based key model.
module tb_ps2_hex_key_rx;
    localparam int DEPTH = 8;
    localparam int TMO   = 100;
    localparam int HB    = 4;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, rd_en, clr;
    logic [3:0] key_data;
    logic       key_valid, overflow, frame_err;
    logic [$clog2(DEPTH):0] key_count;

    ps2_hex_key_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .clr(clr), .key_data(key_data), .key_valid(key_valid),
        .key_count(key_count), .overflow(overflow), .frame_err(frame_err));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int err_seen = 0, err_exp = 0;
    logic [3:0] q[$];
    bit m_ovf, m_brk, m_ext;
    logic [7:0] codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int hex_of(input logic [7:0] b);
        for (int i = 0; i < 16; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic nwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 32'(key_valid), 32'(q.size() != 0));
        chk({tag, "_count"}, 32'(key_count), 32'(q.size()));
        chk({tag, "_data"},  32'(key_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, "_ferr"},  32'(err_seen),  32'(err_exp));
    endtask

    task automatic model_frame(input logic [7:0] b, input bit flip, input bit bad_stop, input bit pop_sync);
        bit ok;
        int h;
        if (pop_sync && q.size() != 0) void'(q.pop_front());
        ok = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
        if (flip) ok = 1'b0;
`endif
        h = hex_of(b);
        if (!ok) err_exp++;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (m_brk || m_ext) begin m_brk = 1'b0; m_ext = 1'b0; end
        else if (h >= 0) begin
            if (q.size() < DEPTH) q.push_back(4'(h));
            else m_ovf = 1'b1;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_sync);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            nwait(HB);
            ps2_clk = 1'b0;
            // rd_en lands on the CHECK cycle, where the push is written
            if (pop_sync && i == 10) begin
                nwait(3); rd_en = 1'b1; nwait(1); rd_en = 1'b0;
            end else nwait(HB);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit bad_stop, input bit pop_sync);
        logic par;
        par = ~(^b) ^ flip;
        send_bits({~bad_stop, par, b, 1'b0}, 11, pop_sync);
        nwait(12);
        model_frame(b, flip, bad_stop, pop_sync);
    endtask

    task automatic pop();
        rd_en = 1'b1; nwait(1); rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic do_clr();
        clr = 1'b1; nwait(1); clr = 1'b0;
        q.delete(); m_ovf = 1'b0;
    endtask

    initial begin
        int r;
        logic [7:0] b;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr = 1'b0;
        nwait(3);
        chk("rst_data", 32'(key_data), 0);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_count", 32'(key_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        rst = 1'b0;
        nwait(2);

        send_frame(8'h16, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h16, 0, 0, 0);
        check_state("release");
        chk("release_key1", 32'(key_data), 1);
        chk("release_cnt1", 32'(key_count), 1);
        pop();
        check_state("drain");

        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'h45, 0, 0, 0);
        send_frame(8'h2B, 0, 0, 0);
        chk("seq_a", 32'(key_data), 32'hA);
        pop(); chk("seq_0", 32'(key_data), 32'h0);
        pop(); chk("seq_f", 32'(key_data), 32'hF);
        pop(); chk("seq_empty", 32'(key_valid), 0);
        check_state("seq");

        for (int i = 0; i < 9; i++) send_frame(codes[i], 0, 0, 0);
        check_state("full");
        chk("full_cnt8", 32'(key_count), 8);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_head", 32'(key_data), 0);
        do_clr();
        check_state("clr");

        send_frame(8'h16, 1, 0, 0);
        check_state("badpar");
        do_clr();

        send_bits(11'b000_0101_0110, 5, 0);
        nwait(TMO + 20);
        err_exp++;
        check_state("timeout");
        send_frame(8'h26, 0, 0, 0);
        chk("after_tmo", 32'(key_data), 3);
        do_clr();

        for (int i = 0; i < 8; i++) send_frame(codes[i + 4], 0, 0, 0);
        send_frame(8'h46, 0, 0, 1);
        check_state("fullpop");
        chk("fullpop_cnt", 32'(key_count), 8);
        chk("fullpop_ovf", 32'(overflow), 0);
        chk("fullpop_head", 32'(key_data), 5);

        send_bits(11'b111_0000_0110, 6, 0);
        rst = 1'b1;
        nwait(1);
        chk("midrst_valid", 32'(key_valid), 0);
        chk("midrst_count", 32'(key_count), 0);
        chk("midrst_data", 32'(key_data), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_ferr", 32'(frame_err), 0);
        nwait(2);
        rst = 1'b0;
        q.delete(); m_ovf = 0; m_brk = 0; m_ext = 0;
        nwait(2);
        send_frame(8'h45, 0, 0, 0);
        check_state("postrst");

        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      b = codes[$urandom_range(0, 15)];
            else if (r == 6) b = 8'hF0;
            else if (r == 7) b = 8'hE0;
            else             b = 8'($urandom);
            send_frame(b, ($urandom_range(0, 7) == 0), (r == 9), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 2) == 0) pop();
            if ($urandom_range(0, 19) == 0) do_clr();
            check_state("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
